// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer.
// Addresses of the optional counters are used only when CSR_COUNTERS_EN is defined.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    typedef enum logic [1:0] {
        CSR_WRITE = 2'b00,
        CSR_SET   = 2'b01,
        CSR_CLEAR = 2'b10,
        CSR_NOP   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        TRAP = 2'b01,
        RET  = 2'b10
    } trap_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest asserted index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end else begin
                valid = valid;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with fixed-priority interrupt entry and mret redirect.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              NUM_IRQ        = 4,
    parameter int              IRQ_CAUSE_BASE = 16,
    parameter logic [XLEN-1:0] RESET_MTVEC    = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       csr_addr,
    input  logic [XLEN-1:0]   csr_write_data,
    input  logic              csr_write_enable,
    input  logic [1:0]        csr_op,
    input  logic              csr_read_enable,
    input  logic              is_mret,
    input  logic [XLEN-1:0]   pc,
    input  logic              pc_valid,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [XLEN-1:0]   csr_read_data,
    output logic [XLEN-1:0]   exc_pc,
    output logic              epc_taken
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    function automatic logic [XLEN-1:0] csr_modify(input logic [XLEN-1:0] old_v,
                                                   input logic [XLEN-1:0] d,
                                                   input csr_op_e         op);
        case (op)
            CSR_WRITE: return d;
            CSR_SET:   return old_v | d;
            CSR_CLEAR: return old_v & ~d;
            default:   return old_v;
        endcase
    endfunction

    logic                mstatus_mie_r;
    logic                mstatus_mpie_r;
    logic [NUM_IRQ-1:0]  mie_r;
    logic [NUM_IRQ-1:0]  mip_r;
    logic [XLEN-3:0]     mtvec_base_r;
    logic                mtvec_mode_r;
    logic [XLEN-3:0]     mepc_r;
    logic [XLEN-1:0]     mcause_r;
    trap_state_e         state_r;
    trap_state_e         state_next_s;
    logic [XLEN-1:0]     exc_pc_r;
    logic                epc_taken_r;

    logic [XLEN-1:0]     csr_old_s;
    logic [XLEN-1:0]     csr_new_s;
    logic                csr_wr_s;
    csr_op_e             csr_op_s;
    logic [NUM_IRQ-1:0]  pend_s;
    logic                pend_valid_s;
    logic [IDX_W-1:0]    pend_idx_s;
    logic [XLEN-1:0]     cause_s;
    logic [XLEN-1:0]     mtvec_pc_s;
    logic [XLEN-1:0]     trap_vec_s;
    logic                take_trap_s;
    logic                take_ret_s;
    logic [XLEN-1:0]     exc_pc_next_s;
    logic                epc_taken_next_s;
    logic                unused_s;

`ifdef CSR_COUNTERS_EN
    logic [63:0]         mcycle_r;
    logic [63:0]         minstret_r;
`endif

    assign csr_op_s = csr_op_e'(csr_op);
    assign csr_wr_s = csr_write_enable && (csr_op_s != CSR_NOP);
    assign unused_s = ^{pc[1:0], cause_s[XLEN-1]};

    // Pre-modify value of the addressed CSR; unimplemented addresses read zero.
    always_comb begin
        csr_old_s = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_old_s[MSTATUS_MIE_BIT]  = mstatus_mie_r;
                csr_old_s[MSTATUS_MPIE_BIT] = mstatus_mpie_r;
            end
            CSR_MIE:    csr_old_s[IRQ_CAUSE_BASE +: NUM_IRQ] = mie_r;
            CSR_MIP:    csr_old_s[IRQ_CAUSE_BASE +: NUM_IRQ] = mip_r;
            CSR_MTVEC:  csr_old_s = {mtvec_base_r, 1'b0, mtvec_mode_r};
            CSR_MEPC:   csr_old_s = {mepc_r, 2'b00};
            CSR_MCAUSE: csr_old_s = mcause_r;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    csr_old_s[31:0] = mcycle_r[31:0];
            CSR_MCYCLEH:   csr_old_s[31:0] = mcycle_r[63:32];
            CSR_MINSTRET:  csr_old_s[31:0] = minstret_r[31:0];
            CSR_MINSTRETH: csr_old_s[31:0] = minstret_r[63:32];
`endif
            default:    csr_old_s = '0;
        endcase
    end

    assign csr_new_s = csr_modify(csr_old_s, csr_write_data, csr_op_s);

    // Read port gated by the enable.
    always_comb begin
        if (csr_read_enable) begin
            csr_read_data = csr_old_s;
        end else begin
            csr_read_data = '0;
        end
    end

    assign pend_s = mip_r & mie_r & {NUM_IRQ{mstatus_mie_r}};

    irq_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_prio (
        .req   (pend_s),
        .valid (pend_valid_s),
        .idx   (pend_idx_s)
    );

    assign cause_s    = XLEN'(IRQ_CAUSE_BASE) + XLEN'(pend_idx_s);
    assign mtvec_pc_s = {mtvec_base_r, 2'b00};
    assign trap_vec_s = mtvec_mode_r ? (mtvec_pc_s + {cause_s[XLEN-3:0], 2'b00}) : mtvec_pc_s;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: mret has priority over a pending interrupt.
    always_comb begin
        state_next_s = RUN;
        case (state_r)
            RUN: begin
                if (is_mret) begin
                    state_next_s = RET;
                end else if (pend_valid_s && pc_valid) begin
                    state_next_s = TRAP;
                end else begin
                    state_next_s = RUN;
                end
            end
            TRAP:    state_next_s = RUN;
            RET:     state_next_s = RUN;
            default: state_next_s = RUN;
        endcase
    end

    // Redirect decisions and next values of the registered outputs.
    always_comb begin
        take_trap_s      = (state_r == RUN) && pend_valid_s && pc_valid && !is_mret;
        take_ret_s       = (state_r == RUN) && is_mret;
        exc_pc_next_s    = exc_pc_r;
        epc_taken_next_s = 1'b0;
        if (take_trap_s) begin
            exc_pc_next_s    = trap_vec_s;
            epc_taken_next_s = 1'b1;
        end else if (take_ret_s) begin
            exc_pc_next_s    = {mepc_r, 2'b00};
            epc_taken_next_s = 1'b1;
        end else begin
            exc_pc_next_s    = exc_pc_r;
            epc_taken_next_s = 1'b0;
        end
    end

    // Registered redirect outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_pc_r    <= '0;
            epc_taken_r <= 1'b0;
        end else begin
            exc_pc_r    <= exc_pc_next_s;
            epc_taken_r <= epc_taken_next_s;
        end
    end

    assign exc_pc    = exc_pc_r;
    assign epc_taken = epc_taken_r;

    // CSR state; hardware trap/mret updates take precedence over software writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_r          <= '0;
            mip_r          <= '0;
            mtvec_base_r   <= RESET_MTVEC[XLEN-1:2];
            mtvec_mode_r   <= RESET_MTVEC[0];
            mepc_r         <= '0;
            mcause_r       <= '0;
        end else begin
            mip_r <= irq;
            if (take_trap_s) begin
                mstatus_mpie_r <= mstatus_mie_r;
                mstatus_mie_r  <= 1'b0;
            end else if (take_ret_s) begin
                mstatus_mie_r  <= mstatus_mpie_r;
                mstatus_mpie_r <= 1'b1;
            end else if (csr_wr_s && (csr_addr == CSR_MSTATUS)) begin
                mstatus_mie_r  <= csr_new_s[MSTATUS_MIE_BIT];
                mstatus_mpie_r <= csr_new_s[MSTATUS_MPIE_BIT];
            end
            if (csr_wr_s && (csr_addr == CSR_MIE)) begin
                mie_r <= csr_new_s[IRQ_CAUSE_BASE +: NUM_IRQ];
            end
            if (csr_wr_s && (csr_addr == CSR_MTVEC)) begin
                mtvec_base_r <= csr_new_s[XLEN-1:2];
                mtvec_mode_r <= csr_new_s[0];
            end
            if (take_trap_s) begin
                mepc_r   <= pc[XLEN-1:2];
                mcause_r <= {1'b1, cause_s[XLEN-2:0]};
            end else begin
                if (csr_wr_s && (csr_addr == CSR_MEPC)) begin
                    mepc_r <= csr_new_s[XLEN-1:2];
                end
                if (csr_wr_s && (csr_addr == CSR_MCAUSE)) begin
                    mcause_r <= csr_new_s;
                end
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    // Free-running and retire counters; a software write replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_r   <= 64'd0;
            minstret_r <= 64'd0;
        end else begin
            if (csr_wr_s && (csr_addr == CSR_MCYCLE)) begin
                mcycle_r <= {mcycle_r[63:32], csr_new_s[31:0]};
            end else if (csr_wr_s && (csr_addr == CSR_MCYCLEH)) begin
                mcycle_r <= {csr_new_s[31:0], mcycle_r[31:0]};
            end else begin
                mcycle_r <= mcycle_r + 64'd1;
            end
            if (csr_wr_s && (csr_addr == CSR_MINSTRET)) begin
                minstret_r <= {minstret_r[63:32], csr_new_s[31:0]};
            end else if (csr_wr_s && (csr_addr == CSR_MINSTRETH)) begin
                minstret_r <= {csr_new_s[31:0], minstret_r[31:0]};
            end else if (pc_valid && (state_r == RUN) && !take_trap_s) begin
                minstret_r <= minstret_r + 64'd1;
            end
        end
    end
`endif

endmodule
